// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if
// Bundles the IF-stage fetch port, the MEM-stage load/store port and the
// single-ported memory port of the unified memory arbiter.
//   slave  : the arbiter's view (consumes requests, drives responses/strobes)
//   master : the environment's view (pipeline stages plus memory)
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic [DATA_W-1:0] if_inst;
  logic              if_valid;
  logic              if_stall;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [3:0]        d_be;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              d_stall;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, if_flush,
    input  d_req, d_we, d_addr, d_be, d_wdata,
    input  mem_rdata,
    output if_inst, if_valid, if_stall,
    output d_rdata, d_valid, d_stall,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output if_req, if_addr, if_flush,
    output d_req, d_we, d_addr, d_be, d_wdata,
    output mem_rdata,
    input  if_inst, if_valid, if_stall,
    input  d_rdata, d_valid, d_stall,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
// Shares one fixed-latency, single-ported instruction/data memory between the
// IF and MEM pipeline stages. Each access takes MEM_LAT+2 cycles: a grant
// cycle carrying the memory strobe, MEM_LAT wait cycles ending with the data
// capture, and a one-cycle response. Stalls freeze the requesting stages.
// Build option: define ARB_RR_EN for round-robin arbitration on ties;
// otherwise data requests always win over fetches.
module unified_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input logic                  clk,
  input logic                  rst,
  unified_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, IF_WAIT, D_WAIT, RESP} state_t;

  localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

  state_t            state;
  logic [2:0]        cnt;
  logic              cur_fetch;
  logic              cur_store;
  logic              cancelled;
  logic [DATA_W-1:0] if_inst_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              fetch_ok;
  logic              grant_d;
  logic              grant_f;
  logic              if_valid_w;
  logic              d_valid_w;

  // A fetch is only eligible when the front end is not being redirected.
  assign fetch_ok = bus.if_req && !bus.if_flush;

`ifdef ARB_RR_EN
  logic last_fetch;

  // Grant in IDLE; on a tie the requester that did not win last time goes.
  always_comb begin
    grant_d = 1'b0;
    grant_f = 1'b0;
    if (!rst && state == IDLE) begin
      if (bus.d_req && fetch_ok) begin
        grant_d = last_fetch;
        grant_f = !last_fetch;
      end else begin
        grant_d = bus.d_req;
        grant_f = fetch_ok;
      end
    end
  end

  // Remember who won the latest grant; starting as fetch hands the first tie to data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_fetch <= 1'b1;
    end else if (grant_d || grant_f) begin
      last_fetch <= grant_f;
    end
  end
`else
  // Grant in IDLE with data always taking precedence over fetch.
  always_comb begin
    grant_d = 1'b0;
    grant_f = 1'b0;
    if (!rst && state == IDLE) begin
      grant_d = bus.d_req;
      grant_f = fetch_ok && !bus.d_req;
    end
  end
`endif

  // The memory strobe and its qualifiers exist only in the grant cycle.
  assign bus.mem_req   = grant_d || grant_f;
  assign bus.mem_we    = grant_d && bus.d_we;
  assign bus.mem_addr  = grant_d ? bus.d_addr : (grant_f ? bus.if_addr : '0);
  assign bus.mem_be    = grant_d ? bus.d_be : (grant_f ? 4'b1111 : 4'b0000);
  assign bus.mem_wdata = grant_d ? bus.d_wdata : '0;

  // Response pulses come from the RESP state; a late flush still kills the fetch pulse.
  assign if_valid_w   = (state == RESP) && cur_fetch && !cancelled && !bus.if_flush;
  assign d_valid_w    = (state == RESP) && !cur_fetch;
  assign bus.if_valid = if_valid_w;
  assign bus.d_valid  = d_valid_w;
  assign bus.if_inst  = if_inst_q;
  assign bus.d_rdata  = d_rdata_q;

  // Each stage is held until its own response arrives (or the fetch is flushed).
  assign bus.if_stall = bus.if_req && !if_valid_w && !bus.if_flush;
  assign bus.d_stall  = bus.d_req && !d_valid_w;

  // Access sequencer: grant, count out the memory latency, capture, respond.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      cur_fetch <= 1'b0;
      cur_store <= 1'b0;
      cancelled <= 1'b0;
      if_inst_q <= '0;
      d_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state     <= D_WAIT;
            cnt       <= CNT_INIT;
            cur_fetch <= 1'b0;
            cur_store <= bus.d_we;
            cancelled <= 1'b0;
          end else if (grant_f) begin
            state     <= IF_WAIT;
            cnt       <= CNT_INIT;
            cur_fetch <= 1'b1;
            cur_store <= 1'b0;
            cancelled <= 1'b0;
          end
        end
        IF_WAIT: begin
          if (bus.if_flush) begin
            cancelled <= 1'b1;
          end
          if (cnt == 3'd0) begin
            if (!cancelled && !bus.if_flush) begin
              if_inst_q <= bus.mem_rdata;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        D_WAIT: begin
          if (cnt == 3'd0) begin
            if (!cur_store) begin
              d_rdata_q <= bus.mem_rdata;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter
// Self-checking bench for unified_mem_arbiter. Directed scenarios cover
// reset, single fetch, data/fetch collision, stores, flushes, reset during an
// access and arbitration order; a randomized run is checked against a
// transaction-level schedule model. Honours ARB_RR_EN like the design.
module tb_unified_mem_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MEM_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   gcyc = 0;

  unified_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  unified_mem_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .MEM_LAT(MEM_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Free-running clock and cycle counter
  always #5 clk = ~clk;

  always @(posedge clk) gcyc <= gcyc + 1;

  // Initial memory image; word 4 (address 0x10) holds an addi instruction
  function automatic logic [31:0] init_word(input int i);
    logic [31:0] v;
    v = 32'(i);
    if (i == 4) return 32'h0050_0093;
    return (v * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  logic [31:0] serve_mem [0:255];
  int          due_cyc   [0:7];
  logic [7:0]  due_idx   [0:7];
  bit          mem_ready = 1'b0;

  // Memory model: returns the addressed word exactly MEM_LAT cycles after a strobe, noise otherwise
  always @(negedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) serve_mem[i] = init_word(i);
      for (int i = 0; i < 8; i++) due_cyc[i] = -1;
      mem_ready = 1'b1;
    end
    bus.mem_rdata = $urandom;
    for (int i = 0; i < 8; i++)
      if (due_cyc[i] == gcyc) bus.mem_rdata = serve_mem[due_idx[i]];
    if (bus.mem_req === 1'b1) begin
      due_cyc[gcyc % 8] = gcyc + MEM_LAT;
      due_idx[gcyc % 8] = bus.mem_addr[9:2];
      if (bus.mem_we === 1'b1)
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b]) serve_mem[bus.mem_addr[9:2]][8*b +: 8] = bus.mem_wdata[8*b +: 8];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic fl,
                               input logic dr, input logic dwe, input logic [31:0] da,
                               input logic [3:0] dbe, input logic [31:0] dwd);
    bus.if_req   = ir;
    bus.if_addr  = ia;
    bus.if_flush = fl;
    bus.d_req    = dr;
    bus.d_we     = dwe;
    bus.d_addr   = da;
    bus.d_be     = dbe;
    bus.d_wdata  = dwd;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  // Leaves the bench just after reset release, at the start of an IDLE cycle
  task automatic applyReset();
    applyIdle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b1, 1'b1, 32'h100, 4'hF, 32'h1234_5678);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_req: got %b want 0", bus.mem_req); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_we: got %b want 0", bus.mem_we); end
    checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
    checks++; if (bus.mem_be !== 4'h0) begin errors++; $display("[TB] FAIL reset_mem_be: got %h want 0", bus.mem_be); end
    checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_wdata: got %h want 0", bus.mem_wdata); end
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_if_valid: got %b want 0", bus.if_valid); end
    checks++; if (bus.d_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_d_valid: got %b want 0", bus.d_valid); end
    checks++; if (bus.if_inst !== 32'h0) begin errors++; $display("[TB] FAIL reset_if_inst: got %h want 0", bus.if_inst); end
    checks++; if (bus.d_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_d_rdata: got %h want 0", bus.d_rdata); end
    applyReset();
  endtask

  task automatic test_fetch();
    bit e_req, e_val, e_stl;
    $display("[TB] test_fetch");
    applyReset();
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    for (int k = 0; k <= MEM_LAT + 2; k++) begin
      if (k > 0) step();
      if (k == MEM_LAT + 2) bus.if_req = 1'b0;
      @(negedge clk);
      e_req = (k == 0);
      e_val = (k == MEM_LAT + 1);
      e_stl = (k <= MEM_LAT);
      checks++; if (bus.mem_req !== e_req) begin errors++; $display("[TB] FAIL fetch_mem_req k=%0d: got %b want %b", k, bus.mem_req, e_req); end
      checks++; if (bus.if_valid !== e_val) begin errors++; $display("[TB] FAIL fetch_if_valid k=%0d: got %b want %b", k, bus.if_valid, e_val); end
      checks++; if (bus.if_stall !== e_stl) begin errors++; $display("[TB] FAIL fetch_if_stall k=%0d: got %b want %b", k, bus.if_stall, e_stl); end
      if (k == 0) begin
        checks++; if (bus.mem_addr !== 32'h10) begin errors++; $display("[TB] FAIL fetch_mem_addr: got %h want 00000010", bus.mem_addr); end
        checks++; if (bus.mem_be !== 4'hF) begin errors++; $display("[TB] FAIL fetch_mem_be: got %h want f", bus.mem_be); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL fetch_mem_we: got %b want 0", bus.mem_we); end
      end
      if (k > MEM_LAT) begin
        checks++; if (bus.if_inst !== 32'h0050_0093) begin errors++; $display("[TB] FAIL fetch_if_inst k=%0d: got %h want 00500093", k, bus.if_inst); end
      end
    end
    applyIdle();
  endtask

  task automatic test_back_to_back();
    bit e_req, e_iv, e_dv, e_is, e_ds;
    $display("[TB] test_back_to_back");
    applyReset();
    applyStimulus(1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0);
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) step();
      if (k == 4) bus.d_req = 1'b0;
      if (k == 8) bus.if_req = 1'b0;
      @(negedge clk);
      e_req = (k == 0) || (k == 4);
      e_dv  = (k == 3);
      e_iv  = (k == 7);
      e_ds  = (k <= 2);
      e_is  = (k <= 6);
      checks++; if (bus.mem_req !== e_req) begin errors++; $display("[TB] FAIL b2b_mem_req k=%0d: got %b want %b", k, bus.mem_req, e_req); end
      checks++; if (bus.d_valid !== e_dv) begin errors++; $display("[TB] FAIL b2b_d_valid k=%0d: got %b want %b", k, bus.d_valid, e_dv); end
      checks++; if (bus.if_valid !== e_iv) begin errors++; $display("[TB] FAIL b2b_if_valid k=%0d: got %b want %b", k, bus.if_valid, e_iv); end
      checks++; if (bus.d_stall !== e_ds) begin errors++; $display("[TB] FAIL b2b_d_stall k=%0d: got %b want %b", k, bus.d_stall, e_ds); end
      checks++; if (bus.if_stall !== e_is) begin errors++; $display("[TB] FAIL b2b_if_stall k=%0d: got %b want %b", k, bus.if_stall, e_is); end
      if (k == 0) begin
        checks++; if (bus.mem_addr !== 32'h100) begin errors++; $display("[TB] FAIL b2b_data_addr: got %h want 00000100", bus.mem_addr); end
      end
      if (k == 4) begin
        checks++; if (bus.mem_addr !== 32'h20) begin errors++; $display("[TB] FAIL b2b_fetch_addr: got %h want 00000020", bus.mem_addr); end
      end
      if (k == 3) begin
        checks++; if (bus.d_rdata !== init_word(64)) begin errors++; $display("[TB] FAIL b2b_d_rdata: got %h want %h", bus.d_rdata, init_word(64)); end
      end
      if (k == 7) begin
        checks++; if (bus.if_inst !== init_word(8)) begin errors++; $display("[TB] FAIL b2b_if_inst: got %h want %h", bus.if_inst, init_word(8)); end
      end
    end
    applyIdle();
  endtask

  task automatic test_store();
    bit          e_req, e_dv;
    logic [31:0] e_rd;
    $display("[TB] test_store");
    applyReset();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0);
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) step();
      if (k == 4) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h104, 4'b0011, 32'hDEAD_BEEF);
      if (k == 8) bus.d_req = 1'b0;
      @(negedge clk);
      e_req = (k == 0) || (k == 4);
      e_dv  = (k == 3) || (k == 7);
      e_rd  = (k >= 3) ? init_word(64) : 32'h0;
      checks++; if (bus.mem_req !== e_req) begin errors++; $display("[TB] FAIL store_mem_req k=%0d: got %b want %b", k, bus.mem_req, e_req); end
      checks++; if (bus.d_valid !== e_dv) begin errors++; $display("[TB] FAIL store_d_valid k=%0d: got %b want %b", k, bus.d_valid, e_dv); end
      checks++; if (bus.d_rdata !== e_rd) begin errors++; $display("[TB] FAIL store_d_rdata k=%0d: got %h want %h", k, bus.d_rdata, e_rd); end
      if (k == 4) begin
        checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("[TB] FAIL store_mem_we: got %b want 1", bus.mem_we); end
        checks++; if (bus.mem_be !== 4'b0011) begin errors++; $display("[TB] FAIL store_mem_be: got %b want 0011", bus.mem_be); end
        checks++; if (bus.mem_addr !== 32'h104) begin errors++; $display("[TB] FAIL store_mem_addr: got %h want 00000104", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL store_mem_wdata: got %h want deadbeef", bus.mem_wdata); end
      end
    end
    applyIdle();
  endtask

  task automatic test_flush();
    bit e_req, e_stl;
    $display("[TB] test_flush");
    applyReset();
    applyStimulus(1'b1, 32'h30, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) step();
      case (k)
        1: begin bus.if_flush = 1'b1; bus.if_addr = 32'h50; end
        2: bus.if_flush = 1'b0;
        7: bus.if_flush = 1'b1;
        8: bus.if_addr = 32'h60;
        9: bus.if_flush = 1'b0;
        default: ;
      endcase
      @(negedge clk);
      e_req = (k == 0) || (k == 4) || (k == 9);
      e_stl = !(k == 1 || k == 7 || k == 8);
      checks++; if (bus.mem_req !== e_req) begin errors++; $display("[TB] FAIL flush_mem_req k=%0d: got %b want %b", k, bus.mem_req, e_req); end
      checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_if_valid k=%0d: got %b want 0", k, bus.if_valid); end
      checks++; if (bus.if_stall !== e_stl) begin errors++; $display("[TB] FAIL flush_if_stall k=%0d: got %b want %b", k, bus.if_stall, e_stl); end
      if (k <= 6) begin
        checks++; if (bus.if_inst !== 32'h0) begin errors++; $display("[TB] FAIL flush_if_inst k=%0d: got %h want 0", k, bus.if_inst); end
      end
      if (k == 4) begin
        checks++; if (bus.mem_addr !== 32'h50) begin errors++; $display("[TB] FAIL flush_new_pc: got %h want 00000050", bus.mem_addr); end
      end
      if (k == 9) begin
        checks++; if (bus.mem_addr !== 32'h60) begin errors++; $display("[TB] FAIL flush_idle_pc: got %h want 00000060", bus.mem_addr); end
      end
    end
    applyIdle();
  endtask

  task automatic test_reset_mid();
    bit          e_req, e_dv;
    logic [31:0] e_rd;
    $display("[TB] test_reset_mid");
    applyReset();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0);
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) step();
      if (k == 4) bus.d_addr = 32'h108;
      if (k == 5) rst = 1'b1;
      if (k == 6) rst = 1'b0;
      @(negedge clk);
      e_req = (k == 0) || (k == 4) || (k == 6);
      e_dv  = (k == 3) || (k == 9);
      if (k < 3) e_rd = 32'h0;
      else if (k < 5) e_rd = init_word(64);
      else if (k < 9) e_rd = 32'h0;
      else e_rd = init_word(66);
      checks++; if (bus.mem_req !== e_req) begin errors++; $display("[TB] FAIL rstmid_mem_req k=%0d: got %b want %b", k, bus.mem_req, e_req); end
      checks++; if (bus.d_valid !== e_dv) begin errors++; $display("[TB] FAIL rstmid_d_valid k=%0d: got %b want %b", k, bus.d_valid, e_dv); end
      checks++; if (bus.d_rdata !== e_rd) begin errors++; $display("[TB] FAIL rstmid_d_rdata k=%0d: got %h want %h", k, bus.d_rdata, e_rd); end
    end
    applyIdle();
  endtask

  task automatic test_arbitration();
    bit          e_req, want_fetch;
    logic [31:0] e_addr;
    $display("[TB] test_arbitration");
    applyReset();
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b1, 1'b0, 32'h200, 4'hF, 32'h0);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) step();
      @(negedge clk);
      e_req = (k % 4 == 0);
`ifdef ARB_RR_EN
      want_fetch = ((k / 4) % 2 == 1);
`else
      want_fetch = 1'b0;
`endif
      e_addr = want_fetch ? 32'h40 : 32'h200;
      checks++; if (bus.mem_req !== e_req) begin errors++; $display("[TB] FAIL arb_mem_req k=%0d: got %b want %b", k, bus.mem_req, e_req); end
      if (e_req) begin
        checks++; if (bus.mem_addr !== e_addr) begin errors++; $display("[TB] FAIL arb_winner k=%0d: got %h want %h", k, bus.mem_addr, e_addr); end
      end
    end
    applyIdle();
  endtask

  task automatic test_random(input int ncyc);
    logic [31:0] ref_mem [0:255];
    logic        ir, dr, dwe;
    logic [31:0] ia, da, dwd, resp_data, exp_inst, exp_rdata;
    logic [3:0]  dbe;
    logic [7:0]  idx;
    int          free_at, resp_at;
    bit          resp_fetch, resp_store, last_fetch, gd, gf, vi, vd, e_is, e_ds;
    $display("[TB] test_random");
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    ir = 1'b0; dr = 1'b0; dwe = 1'b0; ia = 32'h0; da = 32'h0; dwd = 32'h0; dbe = 4'h0;
    free_at = 0; resp_at = -1; resp_fetch = 1'b0; resp_store = 1'b0; resp_data = 32'h0;
    last_fetch = 1'b1; exp_inst = 32'h0; exp_rdata = 32'h0; vi = 1'b0; vd = 1'b0;
    applyReset();
    for (int k = 0; k < ncyc; k++) begin
      if (k > 0) step();
      if (vi) ir = 1'b0;
      if (vd) dr = 1'b0;
      if (!ir && $urandom_range(0, 2) == 0) begin
        ir = 1'b1;
        ia = {22'd0, 1'b1, 7'($urandom), 2'b00};
      end
      if (!dr && $urandom_range(0, 2) == 0) begin
        dr  = 1'b1;
        dwe = 1'($urandom);
        da  = {22'd0, 1'b1, 7'($urandom), 2'b00};
        dbe = 4'($urandom);
        dwd = $urandom;
      end
      applyStimulus(ir, ia, 1'b0, dr, dwe, da, dbe, dwd);
      @(negedge clk);
      gd = 1'b0;
      gf = 1'b0;
      if (k >= free_at && (ir || dr)) begin
`ifdef ARB_RR_EN
        if (ir && dr) gf = !last_fetch;
        else gf = ir;
`else
        gf = ir && !dr;
`endif
        gd = !gf;
      end
      vi = (k == resp_at) && resp_fetch;
      vd = (k == resp_at) && !resp_fetch;
      if (vi) exp_inst = resp_data;
      if (vd && !resp_store) exp_rdata = resp_data;
      e_is = ir && !vi;
      e_ds = dr && !vd;
      checks++; if (bus.mem_req !== (gd || gf)) begin errors++; $display("[TB] FAIL rnd_mem_req k=%0d: got %b want %b", k, bus.mem_req, gd || gf); end
      checks++; if (bus.if_valid !== vi) begin errors++; $display("[TB] FAIL rnd_if_valid k=%0d: got %b want %b", k, bus.if_valid, vi); end
      checks++; if (bus.d_valid !== vd) begin errors++; $display("[TB] FAIL rnd_d_valid k=%0d: got %b want %b", k, bus.d_valid, vd); end
      checks++; if (bus.if_inst !== exp_inst) begin errors++; $display("[TB] FAIL rnd_if_inst k=%0d: got %h want %h", k, bus.if_inst, exp_inst); end
      checks++; if (bus.d_rdata !== exp_rdata) begin errors++; $display("[TB] FAIL rnd_d_rdata k=%0d: got %h want %h", k, bus.d_rdata, exp_rdata); end
      checks++; if (bus.if_stall !== e_is) begin errors++; $display("[TB] FAIL rnd_if_stall k=%0d: got %b want %b", k, bus.if_stall, e_is); end
      checks++; if (bus.d_stall !== e_ds) begin errors++; $display("[TB] FAIL rnd_d_stall k=%0d: got %b want %b", k, bus.d_stall, e_ds); end
      if (gd || gf) begin
        checks++; if (bus.mem_addr !== (gf ? ia : da)) begin errors++; $display("[TB] FAIL rnd_mem_addr k=%0d: got %h want %h", k, bus.mem_addr, gf ? ia : da); end
        checks++; if (bus.mem_we !== (gd && dwe)) begin errors++; $display("[TB] FAIL rnd_mem_we k=%0d: got %b want %b", k, bus.mem_we, gd && dwe); end
        checks++; if (bus.mem_be !== (gf ? 4'hF : dbe)) begin errors++; $display("[TB] FAIL rnd_mem_be k=%0d: got %h want %h", k, bus.mem_be, gf ? 4'hF : dbe); end
        if (gd && dwe) begin
          checks++; if (bus.mem_wdata !== dwd) begin errors++; $display("[TB] FAIL rnd_mem_wdata k=%0d: got %h want %h", k, bus.mem_wdata, dwd); end
        end
        free_at    = k + MEM_LAT + 2;
        resp_at    = k + MEM_LAT + 1;
        resp_fetch = gf;
        last_fetch = gf;
        resp_store = gd && dwe;
        idx        = gf ? ia[9:2] : da[9:2];
        resp_data  = ref_mem[idx];
        if (resp_store)
          for (int b = 0; b < 4; b++)
            if (dbe[b]) ref_mem[idx][8*b +: 8] = dwd[8*b +: 8];
      end
    end
    applyIdle();
  endtask

  // Scenario sequence followed by the one-line summary
  initial begin
    applyIdle();
    test_reset();
    test_fetch();
    test_back_to_back();
    test_store();
    test_flush();
    test_reset_mid();
    test_arbitration();
    test_random(400);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
